// File: rtl/md4_match_monitor_pkg.sv
// ============================================================================
// Module   : md4_pkg
// Purpose  : Shared types and constants for the MD4 match monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package md4_pkg;

    localparam int MD4_DIGEST_BITS = 128;

    typedef logic [MD4_DIGEST_BITS-1:0] md4_digest_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2
    } match_state_t;

endpackage

`default_nettype wire

// File: rtl/md4_match_monitor_if.sv
// ============================================================================
// Module   : md4_match_monitor_if
// Purpose  : Control, digest and result signals of the MD4 match monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md4_match_monitor_if #(
    parameter int p_inp_data_len = 32,
    parameter int p_width        = 32,
    parameter int p_errcnt_width = 16
);
    logic                        start;
    logic                        abort;
    logic                        targetLoad;
    logic [p_width*4-1:0]        targetDigest;
    logic                        candValid;
    logic [p_inp_data_len-1:0]   candData;
    logic [p_width*4-1:0]        digestIn;
    logic                        correctableError;
    logic                        foundAck;
    logic                        busy;
    logic                        found;
    logic [p_inp_data_len-1:0]   foundData;
    logic [p_errcnt_width-1:0]   errCount;

    modport master (
        output start, abort, targetLoad, targetDigest, candValid, candData,
               digestIn, correctableError, foundAck,
        input  busy, found, foundData, errCount
    );

    modport slave (
        input  start, abort, targetLoad, targetDigest, candValid, candData,
               digestIn, correctableError, foundAck,
        output busy, found, foundData, errCount
    );
endinterface

`default_nettype wire

// File: rtl/md4_match_monitor_tag_delay.sv
// ============================================================================
// Module   : md4_tag_delay
// Purpose  : Fixed-depth {valid, data} shift line aligning candidate tags
//            with the pipeline output. Only the valid bits are reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md4_tag_delay #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 48
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_valid,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_valid,
    output logic      [DATA_W-1:0] o_data
);
    logic              r_valid [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_valid[0] <= 1'b0;
        else     r_valid[0] <= i_valid;
    end

    always_ff @(posedge clk) begin
        r_data[0] <= i_data;
    end

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_valid[i] <= 1'b0;
                else     r_valid[i] <= r_valid[i-1];
            end

            always_ff @(posedge clk) begin
                r_data[i] <= r_data[i-1];
            end
        end
    endgenerate

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
endmodule

`default_nettype wire

// File: rtl/md4_match_monitor.sv
// ============================================================================
// Module   : md4_match_monitor
// Purpose  : Matches voted MD4 digests against a target, captures the first
//            matching candidate; MD4_MATCH_ERRCNT_EN adds an error counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md4_match_monitor
    import md4_pkg::*;
#(
    parameter int p_inp_data_len = 32,
    parameter int p_width        = 32,
    parameter int p_latency      = 48,
    parameter int p_errcnt_width = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    md4_match_monitor_if.slave bus
);
    localparam int c_digest_w = p_width * 4;

    match_state_t              r_state;
    match_state_t              w_state_next;
    logic [c_digest_w-1:0]     r_target;
    logic [p_inp_data_len-1:0] r_found_data;
    logic                      w_d_valid;
    logic [p_inp_data_len-1:0] w_d_data;
    logic                      w_hit;
    logic                      w_capture;

    md4_tag_delay #(
        .DATA_W (p_inp_data_len),
        .DEPTH  (p_latency)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.candValid),
        .i_data  (bus.candData),
        .o_valid (w_d_valid),
        .o_data  (w_d_data)
    );

    assign w_hit = w_d_valid && (bus.digestIn == r_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_next = SEARCH;
            SEARCH:  if (w_hit) begin
                         w_state_next = FOUND;
                         w_capture    = 1'b1;
                     end
            FOUND:   if (bus.foundAck) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // Abort overrides every other transition, including a same-cycle capture.
        if (bus.abort) begin
            w_state_next = IDLE;
            w_capture    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target     <= '0;
            r_found_data <= '0;
        end else begin
            if (r_state == IDLE && bus.targetLoad) r_target <= bus.targetDigest;
            if (w_capture)                         r_found_data <= w_d_data;
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.found     = (r_state == FOUND);
    assign bus.foundData = r_found_data;

`ifdef MD4_MATCH_ERRCNT_EN
    logic [p_errcnt_width-1:0] r_err_count;

    // Start wins over a coincident error event, so a new session begins at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_count <= '0;
        else if (bus.start)
            r_err_count <= '0;
        else if (w_d_valid && bus.correctableError && (r_err_count != '1))
            r_err_count <= r_err_count + p_errcnt_width'(1);
    end

    assign bus.errCount = r_err_count;
`else
    logic w_unused_err;
    assign w_unused_err = bus.correctableError;
    assign bus.errCount = '0;
`endif
endmodule

`default_nettype wire
